// File: rtl/pipelined_rc_adder.sv
// pipelined_rc_adder
// WIDTH-bit add/subtract split into STAGES = WIDTH/SEG ripple segments, one
// segment per register stage. Each stage carries the still-unprocessed upper
// operand slices forward and accumulates the finished lower sum slices, so the
// complete result lines up at the last stage. A single advance signal moves the
// whole pipe; when the output is blocked every stage holds.
module pipelined_rc_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipelined_rc_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end

  // Bit-serial ripple over one segment; returns {carry_out, segment_sum}.
  function automatic logic [SEG:0] ripple(input logic [SEG-1:0] x,
                                          input logic [SEG-1:0] y,
                                          input logic           ci);
    logic [SEG-1:0] s;
    logic           c;
    c = ci;
    s = '0;
    for (int i = 0; i < SEG; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is a + ~b + 1, so invert B and force the carry-in.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? 1'b1 : cin;
  end

  // The pipe moves whenever the output slot is empty or being drained.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SEG;

    logic [SEG-1:0]    seg_a, seg_b, seg_s;
    logic              c_in, v_in, c_out;
    logic              v_q, v_d, c_q, c_d;
    logic [LO+SEG-1:0] s_q, s_d, s_cat;

    if (k == 0) begin : g_src
      assign seg_a = a[SEG-1:0];
      assign seg_b = b_eff[SEG-1:0];
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign s_cat = seg_s;
    end else begin : g_src
      assign seg_a = g_stg[k-1].g_up.a_q[SEG-1:0];
      assign seg_b = g_stg[k-1].g_up.b_q[SEG-1:0];
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign s_cat = {seg_s, g_stg[k-1].s_q};
    end

    // Segment add and next-state for the token, carry and accumulated sum.
    always_comb begin
      {c_out, seg_s} = ripple(seg_a, seg_b, c_in);
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (adv) begin
        v_d = v_in;
        c_d = c_out;
        s_d = s_cat;
      end
    end

    // Stage register: token valid, carry to next segment, finished sum bits.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_up
      localparam int HI = WIDTH - (k + 1) * SEG;

      logic [HI-1:0] up_a, up_b;
      logic [HI-1:0] a_q, a_d, b_q, b_d;

      if (k == 0) begin : g_upsrc
        assign up_a = a[WIDTH-1:SEG];
        assign up_b = b_eff[WIDTH-1:SEG];
      end else begin : g_upsrc
        assign up_a = g_stg[k-1].g_up.a_q[HI+SEG-1:SEG];
        assign up_b = g_stg[k-1].g_up.b_q[HI+SEG-1:SEG];
      end

      // Upper operand slices ride along with the token until their stage.
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = up_a;
          b_d = up_b;
        end
      end

      // Register for the not-yet-added operand slices.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic c_msb, ovf_q, ovf_d;

      // Carry into the MSB is recovered from the MSB sum bit; overflow is
      // that carry disagreeing with the carry out.
      always_comb begin
        c_msb = seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_s[SEG-1];
        ovf_d = adv ? (c_msb ^ c_out) : ovf_q;
      end

      // Signed-overflow flag registered alongside the final segment.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Bench for pipelined_rc_adder: 16/4 instance against an arithmetic model,
// plus an 8/8 instance for the single-stage configuration.
module tb_pipelined_rc_adder;

  localparam int W  = 16;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  a, b, sum;

  logic          v8, rdy8, cin8, sub8, ov8, ordy8, cout8, ovf8;
  logic [7:0]    a8, b8, s8;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_waits = 0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_rc_adder #(.WIDTH(16), .SEG(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_rc_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8),
    .out_ready(ordy8), .sum(s8), .cout(cout8), .ovf(ovf8)
  );

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    int ux, uy, sx, sy, ur, sr;
    logic c, o;
    logic [W-1:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end else begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      c  = (ur > 65535);
    end
    r = ur[W-1:0];
    o = (sr > 32767) || (sr < -32768);
    return {o, c, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output compare: every cycle out_valid is high, the head of the model
  // queue must be on the output (also catches unstable held outputs).
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out: got out_valid=1 sum=%0h expected no output", sum);
        end else begin
          chk("sum", 32'(sum), 32'(exp_q[0][W-1:0]));
          chk("cout", 32'(cout), 32'(exp_q[0][W]));
          chk("ovf", 32'(ovf), 32'(exp_q[0][W+1]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Present one op and hold it until it will be taken at the next edge.
  task automatic push(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic ts);
    int guard;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
      n_waits++;
    end
    if (guard >= 200) chk("push_timeout", 32'(guard), 32'd0);
  endtask

  task automatic push_rand();
    push(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Single op into an empty pipe; checks latency and literal result.
  task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    int lat;
    idle(ST + 2);
    push(ta, tb, tc, ts);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk({nm, "_lat"}, 32'(lat), 32'(ST));
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic op8(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                     input logic ts, input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a8 = ta; b8 = tb; sub8 = ts; cin8 = 1'b0; v8 = 1'b1;
    #1;
    chk({nm, "_rdy"}, 32'(rdy8), 32'd1);
    @(negedge clk);
    v8 = 1'b0;
    #1;
    chk({nm, "_valid"}, 32'(ov8), 32'd1);
    chk({nm, "_sum"}, 32'(s8), 32'(es));
    chk({nm, "_cout"}, 32'(cout8), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf8), 32'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, w0;
    logic [W-1:0] held;
    reset_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; ordy8 = 1'b1;

    // Model pinned to hand-computed values.
    chk("pin_add", 32'(model(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'h0_5555);
    chk("pin_sub", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0_FFFE);
    chk("pin_ovf", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h3_7FFF);
    chk("pin_wrap", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h1_0000);

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    directed("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub_cin", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);

    // Streaming: 128 back-to-back random ops.
    idle(ST + 2);
    n0 = n_out;
    w0 = n_waits;
    for (int i = 0; i < 128; i++) push_rand();
    idle(ST + 4);
    chk("stream_count", 32'(n_out - n0), 32'd128);
    chk("stream_stalls", 32'(n_waits - w0), 32'd0);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: fill the pipe with the output blocked, hold 6 cycles.
    idle(ST + 2);
    n0 = n_out;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < ST; i++) push_rand();
    held = '0;
    fork
      push_rand();
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          #1;
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
          if (i == 0) held = sum;
          else chk("bp_sum_held", 32'(sum), 32'(held));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 3; i++) push_rand();
    idle(ST + 4);
    chk("bp_count", 32'(n_out - n0), 32'(ST + 4));
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with ops in flight and a valid output showing.
    idle(ST + 2);
    n0 = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_rand();
    idle(1);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_sum", 32'(sum), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    idle(ST + 6);
    chk("rst_no_stale", 32'(n_out - n0), 32'd0);
    directed("post_rst", 16'hABCD, 16'h1111, 1'b0, 1'b1, 16'h9ABC, 1'b1, 1'b0);

    // Single-stage configuration.
    op8("w8_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("w8_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("w8_sub", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
